sap1_mar_loader: RTL and testbench
==================================

Name: sap1_mar_loader

Overview:
- Memory-address-register plus program-mode write sequencer sitting directly upstream of the SAP-1 16-word RAM (two 4-bit ci74189 slices side by side).
- Run mode: holds the 4-bit address loaded from the W bus and passes the control unit's chip-enable through to the RAM.
- Program mode: turns one front-panel write request into a clean, glitch-free RAM write cycle (address/data setup, n_we pulse, hold) on the RAM's n_ce/n_we pins.

Parameters:
- ADDR_W, 4, RAM address width (16 words).
- DATA_W, 8, RAM word width (two 4-bit RAM slices).
- WE_CYCLES, 2, clocks that ram_n_we is held low per write; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  reset, asynchronous, active-high.
- prog  in  1  1 = program mode, 0 = run mode.
- n_lm  in  1  active-low MAR load from bus (run mode only).
- n_ce_in  in  1  active-low RAM enable from the control word (run mode).
- bus_in  in  ADDR_W  low nibble of the W bus.
- sw_addr  in  ADDR_W  front-panel address switches.
- sw_data  in  DATA_W  front-panel data switches.
- wr_req  in  1  front-panel write button, level, synchronous to clk.
- mar_q  out  ADDR_W  current MAR contents.
- ram_a  out  ADDR_W  RAM address.
- ram_d  out  DATA_W  RAM write data.
- ram_n_ce  out  1  RAM chip enable, active-low.
- ram_n_we  out  1  RAM write enable, active-low.
- wr_busy  out  1  high while a write cycle is in progress.
- wr_done  out  1  one-clock pulse when a write cycle completes.

Behaviour:
- Reset (async, clr=1): mar_q=0, latched address=0, latched data=0, state=IDLE, ram_n_we=1, ram_n_ce=1, wr_busy=0, wr_done=0. ram_n_we/ram_n_ce deassert immediately, even mid-pulse.
- MAR: at a rising clk with prog=0 and n_lm=0, mar_q <= bus_in. Otherwise it holds. It never loads in program mode.
- Effective mode register (mode_q):
  - Samples prog only while state=IDLE.
  - A prog change mid-write is ignored until the cycle finishes, so writes are atomic.
- Run mode (mode_q=0):
  - ram_a=mar_q, ram_n_ce=n_ce_in (combinational pass-through), ram_n_we=1.
  - ram_d = latched data; the RAM ignores it.
- Program mode: ram_a = latched address, ram_d = latched data. ram_n_we and ram_n_ce are registered outputs.
- Edge detect: a rise is wr_req=1 with the previous-cycle wr_req=0. Exactly one write per rise; holding the button does not repeat.
- FSM states IDLE, SETUP, WRITE, HOLD:
  - IDLE: ram_n_ce=1 (program mode), ram_n_we=1. On rise with mode_q=1: latch sw_addr/sw_data, go to SETUP, wr_busy=1. A rise in run mode is ignored.
  - SETUP (1 clk): ram_n_ce=0, ram_n_we=1. Next state is WRITE.
  - WRITE (WE_CYCLES clks, 4-bit down-counter): ram_n_ce=0, ram_n_we=0. When the count expires, go to HOLD.
  - HOLD (1 clk): ram_n_ce=0, ram_n_we=1. Next state is IDLE; wr_done=1 for that one clock; wr_busy falls.
- Latency: rise seen at edge N gives ram_n_we low over edges N+2..N+1+WE_CYCLES and wr_done at N+3+WE_CYCLES (5 clks for the default).
- A rise during SETUP/WRITE/HOLD is dropped.
- The address/data latches do not change while wr_busy=1, so switch changes mid-cycle have no effect.
- ram_a and ram_d are stable from SETUP through HOLD inclusive.

Optional Feature:
- Macro SAP1_AUTOINC_EN.
- Defined:
  - On the first write after mode_q goes 0->1, the address is taken from sw_addr.
  - Each later program-mode write uses latched address + 1, wrapping 15->0.
  - Re-entering program mode re-seeds from sw_addr.
  - mar_q shows the latched address while in program mode.
- Undefined: every write uses sw_addr, and mar_q always shows the MAR.

Decomposition:
- Package sap1_pkg holds the ADDR_W/DATA_W defaults, the loader state enum (IDLE, SETUP, WRITE, HOLD) and the WE counter width.
- One sub-module, sap1_rise_det: registered single-bit rising-edge detector with async active-high clr.

Test Plan:
- Reset mid-write: clr asserted during WRITE -> ram_n_we=1 and ram_n_ce=1 in the same delta; mar_q=0; state IDLE; no wr_done.
- Run-mode MAR load: prog=0, bus_in=4'hA, n_lm=0 for one clk -> mar_q=4'hA and ram_a=4'hA. With n_ce_in=0 -> ram_n_ce=0, ram_n_we=1. With n_lm=1, a change of bus_in leaves mar_q at 4'hA.
- Program write: prog=1, sw_addr=4'h3, sw_data=8'h5C, wr_req pulsed -> SETUP, then ram_n_we low for exactly 2 clks, then wr_done at +5 clks. ram_a=3 and ram_d=8'h5C are stable throughout. RAM readback at address 3 gives 8'h5C.
- Held button: wr_req held high for 20 clks -> exactly one wr_done; a second rise while wr_busy=1 is dropped.
- Mode change mid-write: prog dropped to 0 during WRITE -> the write completes (wr_done pulses), then ram_a switches to mar_q.
- SAP1_AUTOINC_EN: seed sw_addr=4'hE, four writes -> addresses E, F, 0, 1 written in order.

Source files
------------

// File: rtl/sap1_pkg.sv
// Shared definitions for the SAP-1 MAR/RAM program loader.
package sap1_pkg;
  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int WE_CNT_W   = 4;

  typedef enum logic [1:0] {IDLE, SETUP, WRITE, HOLD} ld_state_e;
endpackage

// File: rtl/sap1_rise_det.sv
// Rising-edge detector: previous level is registered, rise_o = d_i & ~prev.
module sap1_rise_det (
  input  logic clk,
  input  logic clr,
  input  logic d_i,
  output logic rise_o
);
  logic prev_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) prev_q <= 1'b0;
    else     prev_q <= d_i;
  end

  assign rise_o = d_i & ~prev_q;
endmodule

// File: rtl/sap1_mar_loader.sv
// SAP-1 memory address register plus front-panel RAM write sequencer.
// Optional build macro SAP1_AUTOINC_EN: auto-incrementing program address.
module sap1_mar_loader
  import sap1_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int WE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              prog,
  input  logic              n_lm,
  input  logic              n_ce_in,
  input  logic [ADDR_W-1:0] bus_in,
  input  logic [ADDR_W-1:0] sw_addr,
  input  logic [DATA_W-1:0] sw_data,
  input  logic              wr_req,
  output logic [ADDR_W-1:0] mar_q,
  output logic [ADDR_W-1:0] ram_a,
  output logic [DATA_W-1:0] ram_d,
  output logic              ram_n_ce,
  output logic              ram_n_we,
  output logic              wr_busy,
  output logic              wr_done
);
  localparam logic [WE_CNT_W-1:0] WE_LOAD = WE_CNT_W'(WE_CYCLES - 1);

  ld_state_e             state_q, state_d;
  logic [WE_CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]     mar_reg_q;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic                  mode_q;
  logic                  n_ce_q, n_we_q, wr_done_q;
  logic                  rise, start;
`ifdef SAP1_AUTOINC_EN
  logic                  seed_q;
`endif

  sap1_rise_det u_rise (
    .clk    (clk),
    .clr    (clr),
    .d_i    (wr_req),
    .rise_o (rise)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start   = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      IDLE: if (rise && mode_q) begin
        state_d = SETUP;
        start   = 1'b1;
      end
      SETUP: begin
        state_d = WRITE;
        cnt_d   = WE_LOAD;
      end
      WRITE: if (cnt_q == '0) state_d = HOLD;
             else             cnt_d   = cnt_q - 1'b1;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (start) begin
      data_d = sw_data;
`ifdef SAP1_AUTOINC_EN
      addr_d = seed_q ? sw_addr : addr_q + 1'b1;
`else
      addr_d = sw_addr;
`endif
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mar_reg_q <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      mode_q    <= 1'b0;
      n_ce_q    <= 1'b1;
      n_we_q    <= 1'b1;
      wr_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      if (!prog && !n_lm) mar_reg_q <= bus_in;
      // Mode is frozen for the whole write cycle, including its start edge.
      if (state_q == IDLE && !start) mode_q <= prog;
      n_ce_q    <= (state_d == IDLE);
      n_we_q    <= (state_d != WRITE);
      wr_done_q <= (state_q == HOLD);
    end
  end

`ifdef SAP1_AUTOINC_EN
  always_ff @(posedge clk or posedge clr) begin
    if (clr)         seed_q <= 1'b1;
    else if (!mode_q) seed_q <= 1'b1;
    else if (start)  seed_q <= 1'b0;
  end
  assign mar_q = mode_q ? addr_q : mar_reg_q;
`else
  assign mar_q = mar_reg_q;
`endif

  // clr forces the pass-through enable high so the RAM is released during reset.
  assign ram_a    = mode_q ? addr_q : mar_reg_q;
  assign ram_d    = data_q;
  assign ram_n_ce = mode_q ? n_ce_q : (n_ce_in | clr);
  assign ram_n_we = mode_q ? n_we_q : 1'b1;
  assign wr_busy  = (state_q != IDLE);
  assign wr_done  = wr_done_q;
endmodule

// File: tb/tb_sap1_mar_loader.sv
// Scoreboard bench for sap1_mar_loader: stimulus queues expected writes, a monitor checks each wr_done.
module tb_sap1_mar_loader;
  localparam int WE = 2;

  logic       clk = 1'b0;
  logic       clr, prog, n_lm, n_ce_in, wr_req;
  logic [3:0] bus_in, sw_addr, mar_q, ram_a;
  logic [7:0] sw_data, ram_d;
  logic       ram_n_ce, ram_n_we, wr_busy, wr_done;

  sap1_mar_loader #(.ADDR_W(4), .DATA_W(8), .WE_CYCLES(WE)) dut (
    .clk(clk), .clr(clr), .prog(prog), .n_lm(n_lm), .n_ce_in(n_ce_in),
    .bus_in(bus_in), .sw_addr(sw_addr), .sw_data(sw_data), .wr_req(wr_req),
    .mar_q(mar_q), .ram_a(ram_a), .ram_d(ram_d), .ram_n_ce(ram_n_ce),
    .ram_n_we(ram_n_we), .wr_busy(wr_busy), .wr_done(wr_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
    int         t;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  int         n_chk = 0, n_fail = 0, cyc = 0, done_cnt = 0;
  logic [7:0] mem [16];
  logic [3:0] tb_last = 4'h0;
  bit         tb_seed = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (!ram_n_ce && !ram_n_we) mem[ram_a] <= ram_d;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: captures address/data at cycle start, counts n_we-low clocks, checks on wr_done.
  int         we_low = 0;
  logic       busy_p = 1'b0, unstable = 1'b0;
  logic [3:0] sa;
  logic [7:0] sd;
  always @(negedge clk) begin
    if (clr) begin
      we_low = 0; busy_p = 1'b0; unstable = 1'b0;
    end else begin
      if (wr_busy && !busy_p) begin
        sa = ram_a; sd = ram_d; unstable = 1'b0; we_low = 0;
      end else if (wr_busy && (ram_a !== sa || ram_d !== sd)) unstable = 1'b1;
      if (!ram_n_we) we_low++;
      busy_p = wr_busy;
      if (wr_done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected wr_done at cycle %0d", cyc);
        end else begin
          e = sb.pop_front();
          chk("write addr", sa, e.a);
          chk("write data", sd, e.d);
          chk("n_we low clocks", we_low, WE);
          chk("wr_done latency", cyc, e.t);
          chk("addr/data stable", unstable, 0);
          chk("ram readback", mem[e.a], e.d);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue(input logic [3:0] a, input logic [7:0] d, input int hold);
    exp_t       x;
    logic [3:0] ea;
    @(negedge clk);
    sw_addr = a; sw_data = d; wr_req = 1'b1;
`ifdef SAP1_AUTOINC_EN
    ea = tb_seed ? a : tb_last + 4'd1;
`else
    ea = a;
`endif
    tb_seed = 1'b0; tb_last = ea;
    x.a = ea; x.d = d; x.t = cyc + 3 + WE;
    sb.push_back(x);
    repeat (hold) @(negedge clk);
    wr_req = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk); n++;
    end
    if (sb.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL write timeout: %0d writes pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  int dc;
  initial begin
    clr = 1'b1; prog = 1'b0; n_lm = 1'b1; n_ce_in = 1'b0; wr_req = 1'b0;
    bus_in = 4'h0; sw_addr = 4'h0; sw_data = 8'h00;
    tick(2);
    chk("reset mar_q", mar_q, 0);
    chk("reset ram_n_we", ram_n_we, 1);
    chk("reset ram_n_ce", ram_n_ce, 1);
    chk("reset wr_busy", wr_busy, 0);
    chk("reset wr_done", wr_done, 0);
    clr = 1'b0;

    // Run-mode MAR load and enable pass-through
    bus_in = 4'hA; n_lm = 1'b0;
    tick(1);
    n_lm = 1'b1;
    chk("mar load", mar_q, 4'hA);
    chk("run ram_a", ram_a, 4'hA);
    chk("run ram_n_ce low", ram_n_ce, 0);
    chk("run ram_n_we", ram_n_we, 1);
    n_ce_in = 1'b1; #1;
    chk("run ram_n_ce high", ram_n_ce, 1);
    bus_in = 4'h5;
    tick(2);
    chk("mar hold", mar_q, 4'hA);

    // Program write
    prog = 1'b1;
    tick(1);
    chk("prog idle ram_n_ce", ram_n_ce, 1);
    issue(4'h3, 8'h5C, 1);
    wait_idle();

    // Held button: single write
    issue(4'h7, 8'hA5, 20);
    wait_idle();
    tick(3);
    chk("held button writes", done_cnt, 2);

    // Second rise and switch changes during a write are ignored
    issue(4'h9, 8'h11, 1);
    tick(1);
    wr_req = 1'b1; sw_addr = 4'hF; sw_data = 8'hFF;
    tick(1);
    wr_req = 1'b0;
    wait_idle();
    tick(3);
    chk("dropped rise writes", done_cnt, 3);

    // prog falls mid-write: write completes, then run mode resumes
    issue(4'h4, 8'h3C, 1);
    tick(1);
    prog = 1'b0; tb_seed = 1'b1;
    wait_idle();
    tick(2);
    chk("post-mode ram_a", ram_a, 4'hA);
    chk("post-mode mar_q", mar_q, 4'hA);
    chk("post-mode ram_n_we", ram_n_we, 1);
    n_ce_in = 1'b0; #1;
    chk("post-mode ram_n_ce", ram_n_ce, 0);
    n_ce_in = 1'b1;

    // Rise in run mode is ignored
    tick(1); wr_req = 1'b1; tick(1); wr_req = 1'b0; tick(8);
    chk("run-mode rise ignored", done_cnt, 4);
    chk("run-mode busy", wr_busy, 0);

    // Four writes from seed E
    prog = 1'b1;
    tick(1);
    for (int i = 0; i < 4; i++) begin
      issue(4'hE, 8'h10 + 8'(i), 1);
      wait_idle();
    end

    // Reset in the middle of the n_we pulse
    dc = done_cnt;
    issue(4'h2, 8'h77, 1);
    tick(1);
    chk("pre-reset ram_n_we", ram_n_we, 0);
    clr = 1'b1; #1;
    chk("mid-reset ram_n_we", ram_n_we, 1);
    chk("mid-reset ram_n_ce", ram_n_ce, 1);
    chk("mid-reset mar_q", mar_q, 0);
    chk("mid-reset wr_busy", wr_busy, 0);
    sb.delete();
    tick(2);
    chk("mid-reset wr_done", wr_done, 0);
    clr = 1'b0; tb_seed = 1'b1;
    tick(8);
    chk("no done after reset", done_cnt, dc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
